// File: rtl/sign_extend_26x32_pkg.sv
// Shared types and helpers for the instruction-field extenders.
// Mode encoding and a generic sign-extend function live here.
package sext_pkg;

  typedef enum logic [1:0] {
    EXT_SEXT,
    EXT_ZEXT,
    EXT_BROFF,
    EXT_JTGT
  } ext_mode_t;

  localparam int IN_W_DEF  = 26;
  localparam int OUT_W_DEF = 32;

  // Sign-extend the low in_w bits of a 32-bit word.
  function automatic logic [31:0] sext(
    input logic [31:0] in,
    input int          in_w
  );
    logic [31:0] m;
    logic [4:0]  sb;
    m  = 32'hFFFF_FFFF << in_w;
    sb = 5'(in_w - 1);
    return in[sb] ? (in | m) : (in & ~m);
  endfunction

endpackage

// File: rtl/sign_extend_26x32_if.sv
// Decode-to-datapath bundle for the field extender.
// master drives the field, slave returns the widened words.
interface sext_if
  import sext_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  ext_mode_t        mode;
  logic [OUT_W-1:0] pc_plus4;
  logic [OUT_W-1:0] comb_out;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;

  modport master (
    output in_data,
    output in_valid,
    output mode,
    output pc_plus4,
    input  comb_out,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  mode,
    input  pc_plus4,
    output comb_out,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/sign_extend_26x32_core.sv
// Combinational mode mux for the field extender.
// Produces the plain sign extension and the mode-selected word.
module sext_core
  import sext_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  in_data,
  input  ext_mode_t        mode,
  input  logic [OUT_W-1:0] pc_plus4,
  output logic [OUT_W-1:0] comb_out,
  output logic [OUT_W-1:0] next_data
);

  localparam int PC_W = OUT_W - IN_W - 2;

  logic [OUT_W-1:0] sx;
  logic [OUT_W-1:0] zx;
  logic [OUT_W-1:0] br;
  logic [OUT_W-1:0] jt;

  assign sx = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign zx = {{(OUT_W-IN_W){1'b0}}, in_data};
  assign br = {sx[OUT_W-3:0], 2'b00};

  // Jump target keeps the PC region bits above the shifted field.
  if (PC_W > 0) begin : g_pc
    logic unused_pc;
    assign jt = {pc_plus4[OUT_W-1:IN_W+2], in_data, 2'b00};
    assign unused_pc = ^pc_plus4[IN_W+1:0];
  end else begin : g_nopc
    logic unused_pc;
    assign jt = {in_data, 2'b00};
    assign unused_pc = ^pc_plus4;
  end

  assign comb_out = sx;

  always_comb begin
    next_data = sx;
    unique case (1'b1)
      (mode == EXT_SEXT):  next_data = sx;
      (mode == EXT_ZEXT):  next_data = zx;
      (mode == EXT_BROFF): next_data = br;
      (mode == EXT_JTGT):  next_data = jt;
      default:             next_data = sx;
    endcase
  end

endmodule

// File: rtl/sign_extend_26x32.sv
// 26-to-32 bit field extender: combinational sign extension plus
// a registered, mode-selected result with a valid flag.
module sign_extend_26x32
  import sext_pkg::*;
#(
  parameter int               IN_W      = IN_W_DEF,
  parameter int               OUT_W     = OUT_W_DEF,
  parameter logic [OUT_W-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic reset,
  sext_if.slave bus
);

  logic [OUT_W-1:0] next_data;
  logic [OUT_W-1:0] data_q;
  logic             valid_q;

  sext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data   (bus.in_data),
    .mode      (bus.mode),
    .pc_plus4  (bus.pc_plus4),
    .comb_out  (bus.comb_out),
    .next_data (next_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid)
        data_q <= next_data;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_sign_extend_26x32.sv
// Directed bench for sign_extend_26x32.
// Vector table for back-to-back captures plus gating/reset sequences.
module tb_sign_extend_26x32;
  import sext_pkg::*;

  typedef struct {
    logic [25:0] d;
    ext_mode_t   m;
    logic [31:0] pc;
    logic [31:0] ec;
    logic [31:0] eo;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[16];

  sext_if #(.IN_W(26), .OUT_W(32)) bus ();

  sign_extend_26x32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, want $finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [25:0] d, input ext_mode_t m,
                              input logic [31:0] pc, input logic [31:0] ec,
                              input logic [31:0] eo);
    vec_t v;
    v.d = d; v.m = m; v.pc = pc; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  task automatic drive(input logic [25:0] d, input ext_mode_t m,
                       input logic [31:0] pc, input logic v);
    bus.in_data  = d;
    bus.mode     = m;
    bus.pc_plus4 = pc;
    bus.in_valid = v;
  endtask

  initial begin
    vecs[0]  = mk(26'h0000000, EXT_SEXT,  32'h0, 32'h00000000, 32'h00000000);
    vecs[1]  = mk(26'h0000002, EXT_SEXT,  32'h0, 32'h00000002, 32'h00000002);
    vecs[2]  = mk(26'h0000006, EXT_SEXT,  32'h0, 32'h00000006, 32'h00000006);
    vecs[3]  = mk(26'h3FFFFFE, EXT_SEXT,  32'h0, 32'hFFFFFFFE, 32'hFFFFFFFE);
    vecs[4]  = mk(26'h0000000, EXT_SEXT,  32'h0, 32'h00000000, 32'h00000000);
    vecs[5]  = mk(26'h2000000, EXT_SEXT,  32'h0, 32'hFE000000, 32'hFE000000);
    vecs[6]  = mk(26'h1FFFFFF, EXT_SEXT,  32'h0, 32'h01FFFFFF, 32'h01FFFFFF);
    vecs[7]  = mk(26'h3FFFFFF, EXT_SEXT,  32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    vecs[8]  = mk(26'h3FFFFFE, EXT_ZEXT,  32'h0, 32'hFFFFFFFE, 32'h03FFFFFE);
    vecs[9]  = mk(26'h3FFFFFE, EXT_BROFF, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFF8);
    vecs[10] = mk(26'h3FFFFFE, EXT_JTGT,  32'h40000004,
                  32'hFFFFFFFE, 32'h4FFFFFF8);
    vecs[11] = mk(26'h3FFFFFE, EXT_SEXT,  32'h0, 32'hFFFFFFFE, 32'hFFFFFFFE);
    vecs[12] = mk(26'h0000010, EXT_JTGT,  32'hA0000000,
                  32'h00000010, 32'hA0000040);
    vecs[13] = mk(26'h2000000, EXT_BROFF, 32'h0, 32'hFE000000, 32'hF8000000);
    vecs[14] = mk(26'h2000000, EXT_ZEXT,  32'h0, 32'hFE000000, 32'h02000000);
    vecs[15] = mk(26'h1FFFFFF, EXT_JTGT,  32'h5FFFFFFC,
                  32'h01FFFFFF, 32'h57FFFFFC);

    drive(26'h2000000, EXT_SEXT, 32'h0, 1'b1);
    #1;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_data", bus.out_data, 32'h0);
    check("rst_comb", bus.comb_out, 32'hFE000000);
    @(posedge clk); #1;
    check("rst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_hold_data", bus.out_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(26'h0, EXT_SEXT, 32'h0, 1'b0);

    // Back-to-back captures, one per cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].d, vecs[i].m, vecs[i].pc, 1'b1);
      #1;
      check($sformatf("vec%0d_comb", i), bus.comb_out, vecs[i].ec);
      @(posedge clk); #1;
      check($sformatf("vec%0d_out", i), bus.out_data, vecs[i].eo);
      check($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
    end

    // Single valid pulse, then three idle cycles.
    @(negedge clk);
    drive(26'h0000123, EXT_ZEXT, 32'h0, 1'b1);
    @(posedge clk); #1;
    check("pulse_valid", {31'd0, bus.out_valid}, 32'd1);
    check("pulse_data", bus.out_data, 32'h00000123);
    @(negedge clk);
    drive(26'h3FFFFFF, EXT_SEXT, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d_valid", i), {31'd0, bus.out_valid}, 32'd0);
      check($sformatf("idle%0d_data", i), bus.out_data, 32'h00000123);
    end

    // Asynchronous reset between edges while valid is high.
    @(negedge clk);
    drive(26'h0000006, EXT_SEXT, 32'h0, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    check("pre_rst_data", bus.out_data, 32'h00000006);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_data", bus.out_data, 32'h0);
    bus.in_data = 26'h3FFFFFF;
    #1;
    check("rst_comb_track", bus.comb_out, 32'hFFFFFFFF);
    @(posedge clk); #1;
    check("rst_ignore_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_ignore_data", bus.out_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(26'h1FFFFFF, EXT_SEXT, 32'h0, 1'b1);
    @(posedge clk); #1;
    check("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    check("post_rst_data", bus.out_data, 32'h01FFFFFF);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_drop", {31'd0, bus.out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sign_extend_26x32.md
Name: sign_extend_26x32

Overview:
- Widens a 26-bit MIPS instruction immediate/target field to 32 bits for the datapath.
- Sits between instruction decode and the ALU / PC-next logic.
- Provides a zero-latency combinational sign-extended output.
- Also provides a registered, mode-selectable output with a valid flag. Modes are sign-extend, zero-extend, branch-offset (sign-extend, shift left 2) and jump-target formation.

Parameters:
- IN_W, 26, input field width; legal range 2..OUT_W-2.
- OUT_W, 32, output word width.
- RESET_VAL, 32'h0, value loaded into out_data on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  IN_W  raw field; bit IN_W-1 is the sign bit.
- in_valid  input  1  qualifies in_data/mode/pc_plus4 for capture.
- mode  input  2  0=SEXT, 1=ZEXT, 2=BROFF, 3=JTGT.
- pc_plus4  input  OUT_W  PC+4; used only in JTGT.
- comb_out  output  OUT_W  combinational sign extension of in_data; ignores mode, clk and reset.
- out_data  output  OUT_W  registered mode result.
- out_valid  output  1  high the cycle after an accepted input.

Behaviour:
- comb_out = {(OUT_W-IN_W){in_data[IN_W-1]}, in_data}. Purely combinational, zero latency. Updates on any in_data change, including during reset.
- Mode functions, computed combinationally into next_data:
  - SEXT: same as comb_out.
  - ZEXT: {(OUT_W-IN_W){1'b0}, in_data}.
  - BROFF: SEXT result shifted left 2 with zero fill; the top 2 bits of the extended value are discarded.
  - JTGT: {pc_plus4[OUT_W-1:IN_W+2], in_data, 2'b00}; the sign bit is not replicated.
- Registered path, 1-cycle latency:
  - On a rising clk with in_valid=1: out_data <= next_data and out_valid <= 1.
  - On a rising clk with in_valid=0: out_valid <= 0 and out_data holds its last value.
- Reset, asserted asynchronously: out_data = RESET_VAL and out_valid = 0 immediately.
  - While reset is high, inputs are ignored by the registered path.
  - The first capture is on the first rising clk after reset deasserts with in_valid=1.
- Reset mid-stream: a pending result is discarded and out_valid drops without waiting for clk.
- Back-to-back valid inputs produce one result per cycle. No backpressure, no stall input.
- All arithmetic is bitwise concatenation; no overflow flag. Boundary inputs:
  - 0x2000000 (most negative) sign-extends to 0xFE000000.
  - 0x1FFFFFF (most positive) sign-extends to 0x01FFFFFF.
- No X-propagation: all outputs are defined at all times after reset.

Decomposition:
- Shared package sext_pkg holds:
  - typedef enum logic [1:0] ext_mode_t {EXT_SEXT, EXT_ZEXT, EXT_BROFF, EXT_JTGT};
  - localparams IN_W_DEF=26 and OUT_W_DEF=32.
  - function sext(in, in_w) for reuse by the 16-bit immediate extender.
- One natural sub-module: sext_core. It is purely combinational: in_data + mode + pc_plus4 -> next_data, and it also drives comb_out.
- The top level adds the output register and the valid flop.

Test Plan:
- Directed combinational values, checked 1 ns after each change on comb_out: in_data=0 -> 0x00000000; 2 -> 0x00000002; 6 -> 0x00000006; 0x3FFFFFE (-2) -> 0xFFFFFFFE; back to 0 -> 0x00000000.
- Sign-bit boundaries: 0x2000000 -> 0xFE000000; 0x1FFFFFF -> 0x01FFFFFF; 0x3FFFFFF -> 0xFFFFFFFF. Check on comb_out and on out_data one cycle later with mode=SEXT.
- Mode sweep with in_data=0x3FFFFFE and in_valid=1 over 4 consecutive cycles:
  - ZEXT -> 0x03FFFFFE.
  - BROFF -> 0xFFFFFFF8.
  - JTGT with pc_plus4=0x40000004 -> 0x4FFFFFF8.
  - SEXT -> 0xFFFFFFFE.
  - Each result appears one cycle after its input, with out_valid=1 every cycle.
- JTGT with in_data=0x0000010 and pc_plus4=0xA0000000 -> out_data=0xA0000040.
- Valid gating: in_valid pulse then low for 3 cycles -> out_valid high exactly 1 cycle; out_data holds its value.
- Asynchronous reset asserted between clock edges while out_valid=1 -> out_valid=0 and out_data=0 immediately. comb_out still tracks in_data during reset. The first capture is on the first edge after release.
